// File: rtl/lc3_reg_file.sv
// LC-3 general-purpose register file: eight 16-bit registers, two combinational
// read ports, one write port and the N/Z/P condition-code register.

// 16-bit register with synchronous clear and load enable.
module lc3_reg16 #(
  parameter int unsigned      WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;

  // Clear wins over enable; otherwise load on enable or hold.
  always_ff @(posedge clock) begin
    if (clr) begin
      q_reg <= RST_VAL;
    end else if (en) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

module lc3_reg_file #(
  parameter int unsigned      WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = 16'h0000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] bus,
  input  logic             ld_reg,
  input  logic [2:0]       dr,
  input  logic             ld_cc,
  input  logic [2:0]       sr1,
  input  logic [2:0]       sr2,
  output logic [WIDTH-1:0] sr1_out,
  output logic [WIDTH-1:0] sr2_out,
  output logic [2:0]       nzp
);

  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

  logic             clr;
  logic [7:0]       wr_en;
  logic [WIDTH-1:0] regs [8];
  logic [2:0]       nzp_reg;
  logic [2:0]       nzp_next;

  // The registers' clear is active-high; reset arrives active-low.
  assign clr = ~reset;

  // 3-to-8 write decoder gated by ld_reg: at most one enable per cycle.
  always_comb begin
    wr_en = '0;
    if (ld_reg) begin
      wr_en[dr] = 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_regs
      lc3_reg16 #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
      ) u_reg (
        .clock (clock),
        .clr   (clr),
        .en    (wr_en[gi]),
        .d     (bus),
        .q     (regs[gi])
      );
    end
  endgenerate

  // Read ports are plain muxes of current contents: no write bypass, so a
  // same-cycle write becomes visible only after the edge.
  assign sr1_out = regs[sr1];
  assign sr2_out = regs[sr2];

  // Classify the bus value into exactly one of N, Z, P.
  always_comb begin
    nzp_next = nzp_reg;
    if (ld_cc) begin
      if (bus[WIDTH-1]) begin
        nzp_next = CC_N;
      end else if (bus == '0) begin
        nzp_next = CC_Z;
      end else begin
        nzp_next = CC_P;
      end
    end
  end

  // Condition-code register; reset puts it in the Z state so it is one-hot.
  always_ff @(posedge clock) begin
    if (!reset) begin
      nzp_reg <= CC_Z;
    end else begin
      nzp_reg <= nzp_next;
    end
  end

  assign nzp = nzp_reg;

endmodule

// File: tb/tb_lc3_reg_file.sv
// Self-checking bench for lc3_reg_file: directed vector table, hand-written
// same-cycle and sweep sequences, then randomized traffic against a model.
module tb_lc3_reg_file;

  logic        clock;
  logic        reset;
  logic [15:0] bus;
  logic        ld_reg;
  logic [2:0]  dr;
  logic        ld_cc;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic [15:0] sr1_out;
  logic [15:0] sr2_out;
  logic [2:0]  nzp;

  int checks;
  int failures;

  lc3_reg_file #(
    .WIDTH   (16),
    .RST_VAL (16'h0000)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .ld_reg  (ld_reg),
    .dr      (dr),
    .ld_cc   (ld_cc),
    .sr1     (sr1),
    .sr2     (sr2),
    .sr1_out (sr1_out),
    .sr2_out (sr2_out),
    .nzp     (nzp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        rst_n;
    logic        ld_reg;
    logic [2:0]  dr;
    logic        ld_cc;
    logic [15:0] bus;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [2:0]  enzp;
  } vec_t;

  vec_t vecs [12];

  // Reference state, derived from the register-file rules directly.
  logic [15:0] mdl_r [8];
  logic [2:0]  mdl_nzp;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [2:0] cc_of(input logic [15:0] v);
    if (v[15]) return 3'b100;
    if (v == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

  task automatic model_edge();
    if (!reset) begin
      for (int k = 0; k < 8; k++) mdl_r[k] = 16'h0000;
      mdl_nzp = 3'b010;
    end else begin
      if (ld_reg) mdl_r[dr] = bus;
      if (ld_cc) mdl_nzp = cc_of(bus);
    end
  endtask

  // Apply current inputs across one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset  = 1'b0;
    bus    = '0;
    ld_reg = 1'b0;
    dr     = '0;
    ld_cc  = 1'b0;
    sr1    = '0;
    sr2    = '0;

    // Expected outputs are sampled after the edge with inputs still applied.
    vecs[0]  = '{1'b0, 1'b1, 3'd0, 1'b1, 16'hFFFF, 3'd0, 3'd7, 16'h0000, 16'h0000, 3'b010};
    vecs[1]  = '{1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 3'd1, 3'd2, 16'h0000, 16'h0000, 3'b010};
    vecs[2]  = '{1'b1, 1'b1, 3'd3, 1'b0, 16'h1234, 3'd3, 3'd5, 16'h1234, 16'h0000, 3'b010};
    vecs[3]  = '{1'b1, 1'b1, 3'd5, 1'b0, 16'hABCD, 3'd3, 3'd5, 16'h1234, 16'hABCD, 3'b010};
    vecs[4]  = '{1'b1, 1'b0, 3'd0, 1'b0, 16'h5555, 3'd4, 3'd6, 16'h0000, 16'h0000, 3'b010};
    vecs[5]  = '{1'b1, 1'b0, 3'd0, 1'b1, 16'h8000, 3'd0, 3'd1, 16'h0000, 16'h0000, 3'b100};
    vecs[6]  = '{1'b1, 1'b0, 3'd0, 1'b1, 16'h0000, 3'd2, 3'd7, 16'h0000, 16'h0000, 3'b010};
    vecs[7]  = '{1'b1, 1'b0, 3'd0, 1'b1, 16'h7FFF, 3'd3, 3'd5, 16'h1234, 16'hABCD, 3'b001};
    vecs[8]  = '{1'b1, 1'b0, 3'd0, 1'b0, 16'h8000, 3'd5, 3'd3, 16'hABCD, 16'h1234, 3'b001};
    vecs[9]  = '{1'b1, 1'b1, 3'd1, 1'b1, 16'h8001, 3'd1, 3'd1, 16'h8001, 16'h8001, 3'b100};
    vecs[10] = '{1'b0, 1'b1, 3'd7, 1'b1, 16'hFFFF, 3'd7, 3'd3, 16'h0000, 16'h0000, 3'b010};
    vecs[11] = '{1'b1, 1'b0, 3'd0, 1'b0, 16'h0000, 3'd1, 3'd5, 16'h0000, 16'h0000, 3'b010};

    for (int i = 0; i < 12; i++) begin
      reset  = vecs[i].rst_n;
      ld_reg = vecs[i].ld_reg;
      dr     = vecs[i].dr;
      ld_cc  = vecs[i].ld_cc;
      bus    = vecs[i].bus;
      sr1    = vecs[i].sr1;
      sr2    = vecs[i].sr2;
      tick();
      check16($sformatf("vec%0d_sr1", i), sr1_out, vecs[i].e1);
      check16($sformatf("vec%0d_sr2", i), sr2_out, vecs[i].e2);
      check3($sformatf("vec%0d_nzp", i), nzp, vecs[i].enzp);
      $display("vec %0d rst=%b ld_reg=%b dr=%0d ld_cc=%b bus=%h sr1=%0d sr2=%0d -> %h %h %b",
               i, reset, ld_reg, dr, ld_cc, bus, sr1, sr2, sr1_out, sr2_out, nzp);
    end

    // State after the table: everything cleared by vector 10.
    for (int k = 0; k < 8; k++) mdl_r[k] = 16'h0000;
    mdl_nzp = 3'b010;
    reset  = 1'b1;
    ld_reg = 1'b0;
    ld_cc  = 1'b0;

    // Reset state over every read selection.
    for (int k = 0; k < 8; k++) begin
      sr1 = 3'(k);
      sr2 = 3'(7 - k);
      #1;
      check16($sformatf("rst_read_sr1_%0d", k), sr1_out, 16'h0000);
      check16($sformatf("rst_read_sr2_%0d", k), sr2_out, 16'h0000);
    end

    // Same-cycle write and read: old value before the edge, new after.
    ld_reg = 1'b1;
    dr     = 3'd2;
    bus    = 16'h00FF;
    sr1    = 3'd2;
    sr2    = 3'd2;
    #1;
    check16("same_cycle_old", sr1_out, 16'h0000);
    model_edge();
    tick();
    ld_reg = 1'b0;
    #1;
    check16("same_cycle_new", sr1_out, 16'h00FF);
    check16("same_cycle_new_sr2", sr2_out, 16'h00FF);
    $display("same-cycle write R2=00FF: sr1_out=%h", sr1_out);

    // Sweep: R[i] = i*1111, then every (sr1, sr2) pair.
    for (int i = 0; i < 8; i++) begin
      ld_reg = 1'b1;
      dr     = 3'(i);
      bus    = 16'(i) * 16'h1111;
      model_edge();
      tick();
    end
    ld_reg = 1'b0;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        sr1 = 3'(a);
        sr2 = 3'(b);
        #1;
        check16($sformatf("sweep_sr1_%0d_%0d", a, b), sr1_out, 16'(a) * 16'h1111);
        check16($sformatf("sweep_sr2_%0d_%0d", a, b), sr2_out, 16'(b) * 16'h1111);
      end
    end
    $display("sweep of 64 read pairs done");

    // Randomized traffic: outputs before each edge must match the model.
    for (int n = 0; n < 400; n++) begin
      reset  = ($urandom_range(0, 15) != 0);
      ld_reg = $urandom_range(0, 1) != 0;
      ld_cc  = $urandom_range(0, 1) != 0;
      dr     = 3'($urandom_range(0, 7));
      sr1    = 3'($urandom_range(0, 7));
      sr2    = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       bus = 16'h0000;
        1:       bus = 16'h8000 | 16'($urandom);
        default: bus = 16'($urandom);
      endcase
      #1;
      check16($sformatf("rand%0d_sr1", n), sr1_out, mdl_r[sr1]);
      check16($sformatf("rand%0d_sr2", n), sr2_out, mdl_r[sr2]);
      check3($sformatf("rand%0d_nzp", n), nzp, mdl_nzp);
      $display("rand %0d rst=%b ld_reg=%b dr=%0d ld_cc=%b bus=%h sr1=%0d sr2=%0d -> %h %h %b",
               n, reset, ld_reg, dr, ld_cc, bus, sr1, sr2, sr1_out, sr2_out, nzp);
      model_edge();
      tick();
    end
    reset = 1'b1;
    #1;
    check3("rand_final_nzp", nzp, mdl_nzp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
